// File: rtl/puf_response_collector.sv
// Arbiter-PUF sequencer: settle, launch, wait for the race and sample it, then majority-vote VOTES trials per response bit.
// One trial takes SETTLE+1+(d+2)+1 cycles. start is ignored while busy; a run stays in DONE until the next start.
module puf_response_collector #(
  parameter int RESP_BITS  = 32,
  parameter int CHAL_WIDTH = 64,
  parameter int VOTES      = 3,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CHAL_WIDTH-1:0] seed,
  output logic [CHAL_WIDTH-1:0] challenge,
  output logic                  arb_rst,
  output logic                  launch,
  input  logic                  arb_done,
  input  logic                  arb_out,
  output logic                  busy,
  output logic                  valid,
  output logic [RESP_BITS-1:0]  response,
  output logic                  timeout_err
);

  localparam int BW = $clog2(RESP_BITS);
  localparam int VW = $clog2(VOTES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                  done_m, done_s, out_m, out_s;
  logic [CHAL_WIDTH-1:0] seed_q;
  logic [BW-1:0]         bit_idx;
  logic [VW-1:0]         trial, ones;
  logic [WW-1:0]         wait_cnt;
  logic [SW-1:0]         settle_cnt;
  logic                  trial_bit;

  logic                  accept, wait_exit, wait_to;
  logic [VW-1:0]         ones_inc, trial_inc;
  logic                  votes_done, last_bit;

  function automatic logic [CHAL_WIDTH-1:0] rotl(input logic [CHAL_WIDTH-1:0] v,
                                                 input logic [BW-1:0] sh);
    logic [2*CHAL_WIDTH-1:0] d;
    int unsigned s;
    s = 32'(sh);
    s = s % CHAL_WIDTH;
    d = {v, v} << s;
    return d[2*CHAL_WIDTH-1 -: CHAL_WIDTH];
  endfunction

  assign ones_inc   = ones + VW'(trial_bit);
  assign trial_inc  = trial + VW'(1);
  assign votes_done = (trial_inc == VW'(VOTES));
  assign last_bit   = (bit_idx == BW'(RESP_BITS - 1));

  always_comb begin
    state_nxt = state;
    arb_rst   = 1'b1;
    launch    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    wait_exit = 1'b0;
    wait_to   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (settle_cnt == SW'(SETTLE - 1)) state_nxt = FIRE;
      end
      FIRE: begin
        arb_rst   = 1'b0;
        launch    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        arb_rst = 1'b0;
        // A done arriving on the final counted cycle still beats the timeout.
        if (done_s) begin
          wait_exit = 1'b1;
          state_nxt = SAMPLE;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          wait_exit = 1'b1;
          wait_to   = 1'b1;
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (votes_done && last_bit) state_nxt = DONE;
        else                        state_nxt = ARM;
      end
      DONE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_m      <= 1'b0;
      done_s      <= 1'b0;
      out_m       <= 1'b0;
      out_s       <= 1'b0;
      seed_q      <= '0;
      challenge   <= '0;
      response    <= '0;
      timeout_err <= 1'b0;
      valid       <= 1'b0;
      bit_idx     <= '0;
      trial       <= '0;
      ones        <= '0;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      trial_bit   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_m <= arb_done;
      done_s <= done_m;
      out_m  <= arb_out;
      out_s  <= out_m;

      settle_cnt <= (state == ARM && state_nxt == ARM) ? settle_cnt + SW'(1) : '0;

      if (accept) begin
        seed_q      <= seed;
        challenge   <= seed;
        response    <= '0;
        timeout_err <= 1'b0;
        valid       <= 1'b0;
        bit_idx     <= '0;
        trial       <= '0;
        ones        <= '0;
      end

      if (state == FIRE) wait_cnt <= '0;
      else if (state == WAIT && !wait_exit) wait_cnt <= wait_cnt + WW'(1);

      if (wait_exit) begin
        trial_bit <= done_s & out_s;
        if (wait_to) timeout_err <= 1'b1;
      end

      if (state == SAMPLE) begin
        if (!votes_done) begin
          ones  <= ones_inc;
          trial <= trial_inc;
        end else begin
          response[bit_idx] <= (ones_inc > VW'(VOTES / 2));
          ones  <= '0;
          trial <= '0;
          if (last_bit) begin
            valid <= 1'b1;
          end else begin
            bit_idx   <= bit_idx + BW'(1);
            challenge <= rotl(seed_q, bit_idx + BW'(1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: behavioural arbiter driven from per-trial plans, plus checks on challenge, settle and latency.
module tb_puf_response_collector;
  localparam int RB = 4;
  localparam int CW = 64;
  localparam int V  = 3;
  localparam int ST = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst, start, arb_done, arb_out;
  logic [CW-1:0] seed, challenge;
  logic          arb_rst, launch, busy, valid, timeout_err;
  logic [RB-1:0] response;

  int errors = 0;
  int checks = 0;

  bit            plan_q[$];
  int            dly_q[$];
  bit            stuck = 1'b0;
  int            launch_cnt = 0;
  logic [CW-1:0] run_seed = '0;

  puf_response_collector #(
    .RESP_BITS(RB), .CHAL_WIDTH(CW), .VOTES(V), .SETTLE(ST), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .challenge(challenge),
    .arb_rst(arb_rst), .launch(launch), .arb_done(arb_done), .arb_out(arb_out),
    .busy(busy), .valid(valid), .response(response), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] rot(input logic [CW-1:0] s, input int k);
    if (k == 0) return s;
    return (s << k) | (s >> (CW - k));
  endfunction

  // Race arbiter stand-in: each launch consumes one planned (bit, delay) pair.
  initial begin : arbiter_model
    int  cnt, rst_run, wcyc, exp_w;
    bit  pend, obit, in_race;
    cnt = 0; rst_run = 0; wcyc = 0; exp_w = 0;
    pend = 1'b0; obit = 1'b0; in_race = 1'b0;
    arb_done = 1'b0;
    arb_out  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_race = 1'b0; pend = 1'b0; rst_run = 0;
        arb_done = 1'b0; arb_out = 1'b0;
      end else if (launch) begin
        chk("launch_arb_rst_low", arb_rst, 1'b0);
        chk("settle_before_launch", 64'(rst_run >= ST), 64'd1);
        chk("challenge_at_launch", challenge, rot(run_seed, (launch_cnt / V) % CW));
        obit = (plan_q.size() > 0) ? plan_q.pop_front() : 1'b0;
        cnt  = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
        exp_w = stuck ? TO : cnt + 2;
        pend = !stuck;
        launch_cnt++;
        in_race = 1'b1; wcyc = 0; rst_run = 0;
      end else if (arb_rst) begin
        if (in_race) chk("wait_cycles", 64'(wcyc), 64'(exp_w));
        in_race = 1'b0; pend = 1'b0;
        arb_done = 1'b0; arb_out = 1'b0;
        rst_run++;
      end else begin
        wcyc++;
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            arb_done = 1'b1;
            arb_out  = obit;
            pend     = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_run(input logic [CW-1:0] s, input bit stk,
                        input logic [RB*V-1:0] bits, input bit poke);
    logic [RB-1:0] exp_r;
    int ones;
    plan_q.delete();
    dly_q.delete();
    for (int b = 0; b < RB; b++) begin
      ones = 0;
      for (int t = 0; t < V; t++) begin
        plan_q.push_back(bits[b*V+t]);
        dly_q.push_back(int'($urandom_range(1, 6)));
        ones += int'(bits[b*V+t]);
      end
      exp_r[b] = stk ? 1'b0 : (2 * ones > V);
    end
    stuck      = stk;
    launch_cnt = 0;
    run_seed   = s;
    start = 1'b1;
    seed  = s;
    step();
    start = 1'b0;
    seed  = {$urandom, $urandom};
    chk("start_busy", busy, 1'b1);
    chk("start_valid_low", valid, 1'b0);
    chk("start_response_clear", response, '0);
    chk("start_timeout_clear", timeout_err, 1'b0);
    if (poke) begin
      repeat (7) step();
      start = 1'b1;
      seed  = ~s;
      step();
      start = 1'b0;
      chk("start_ignored_busy", busy, 1'b1);
    end
    for (int i = 0; i < 3000 && !valid; i++) step();
    chk("run_valid", valid, 1'b1);
    chk("run_busy_low", busy, 1'b0);
    chk("run_response", response, exp_r);
    chk("run_timeout_err", timeout_err, stk);
    chk("run_launches", 64'(launch_cnt), 64'(RB * V));
    chk("done_arb_rst", arb_rst, 1'b1);
  endtask

  initial begin
    logic [RB*V-1:0] bits;
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    step();
    step();
    chk("reset_arb_rst", arb_rst, 1'b1);
    chk("reset_launch", launch, 1'b0);
    chk("reset_challenge", challenge, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_response", response, '0);
    chk("reset_timeout_err", timeout_err, 1'b0);
    rst = 1'b0;
    step();

    // All trials report 1: every response bit set.
    do_run({$urandom, $urandom}, 1'b0, '1, 1'b0);

    // Directed votes: bit0 = 1,0,1 and bit1 = 0,0,1, upper bits random; started from DONE.
    bits = RB*V'($urandom);
    bits[2:0] = 3'b101;
    bits[5:3] = 3'b100;
    do_run({$urandom, $urandom}, 1'b0, bits, 1'b0);
    chk("directed_bit0", response[0], 1'b1);
    chk("directed_bit1", response[1], 1'b0);

    // Stuck arbiter: every trial times out.
    do_run({$urandom, $urandom}, 1'b1, '1, 1'b0);

    // Seed 1: challenge walks 1,2,4,8 across the bits.
    do_run(64'h1, 1'b0, RB*V'($urandom), 1'b0);
    chk("seed1_last_challenge", challenge, 64'h8);

    // Start pulsed mid-run must not disturb the run.
    for (int r = 0; r < 3; r++) do_run({$urandom, $urandom}, 1'b0, RB*V'($urandom), 1'b1);

    // Reset during WAIT.
    plan_q.delete();
    dly_q.delete();
    for (int i = 0; i < RB * V; i++) begin
      plan_q.push_back(1'b1);
      dly_q.push_back(6);
    end
    stuck = 1'b0;
    launch_cnt = 0;
    run_seed = 64'hA5A5_0000_1234_5678;
    start = 1'b1;
    seed  = run_seed;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && !launch; i++) step();
    chk("reset_test_launch_seen", launch, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrun_rst_arb_rst", arb_rst, 1'b1);
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_valid", valid, 1'b0);
    chk("midrun_rst_response", response, '0);
    chk("midrun_rst_challenge", challenge, '0);
    chk("midrun_rst_launch", launch, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Recovery after the mid-run reset.
    do_run({$urandom, $urandom}, 1'b0, RB*V'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
